ins_fetch_queue: RTL and testbench

Instruction fetch front-end that sits directly upstream of the instruction-code converter/decoder.
- Generates sequential fetch addresses and issues them to the instruction memory with a request/grant handshake.
- Buffers in-order returned words in a DEPTH-entry queue.
- Presents the head instruction, already split into op/rs/rt/funct fields with a valid flag, to the decoder.
- Supports a redirect (branch/jump/exception) that flushes the queue and discards in-flight responses.

---
 rtl/ins_fetch_queue.sv | 125 ++++++++++++
 tb/tb_ins_fetch_queue.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ins_fetch_queue.sv
// Instruction fetch front-end: sequential fetch with request/grant credit control,
// in-order response queue, decoder field split, and redirect flush with response dropping.
module ins_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        dec_ready,
  output logic        dec_valid,
  output logic [31:0] dec_ins,
  output logic [31:0] dec_pc,
  output logic [5:0]  dec_op,
  output logic [5:0]  dec_rs,
  output logic [5:0]  dec_rt,
  output logic [5:0]  dec_funct
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   ins_mem_q [DEPTH];
  logic [31:0]   ins_mem_d [DEPTH];
  logic [31:0]   pc_mem_q  [DEPTH];
  logic [31:0]   pc_mem_d  [DEPTH];

  logic [CW:0]   credit;
  logic [31:0]   redirect_pc_aligned;
  logic          grant;
  logic          pop;
  logic          push;

  // Slots are reserved at request time, so a granted word always has room on return.
  assign credit              = {1'b0, count_q} + {1'b0, outst_q};
  assign redirect_pc_aligned = redirect_pc & ~32'h3;
  assign imem_req            = !rst && !redirect_valid && (credit < DEPTH_W);
  assign imem_addr           = fetch_pc_q;
  assign grant               = imem_req && imem_gnt;
  assign dec_valid           = (count_q != '0);
  assign pop                 = dec_valid && dec_ready && !redirect_valid;
  assign push                = imem_rvalid && !redirect_valid && (drop_cnt_q == '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    ins_mem_d  = ins_mem_q;
    pc_mem_d   = pc_mem_q;
    outst_d    = outst_q + CW'(grant) - CW'(imem_rvalid);

    if (grant) fetch_pc_d = fetch_pc_q + 32'd4;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc_aligned;
      resp_pc_d  = redirect_pc_aligned;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      // Everything still in flight after this cycle belongs to the old stream.
      drop_cnt_d = outst_q - CW'(imem_rvalid);
    end else begin
      if (imem_rvalid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
      if (push) begin
        ins_mem_d[wr_ptr_q] = imem_rdata;
        pc_mem_d[wr_ptr_q]  = resp_pc_q;
        wr_ptr_d            = wr_ptr_q + PW'(1);
        resp_pc_d           = resp_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ins_mem_q[i] <= '0;
        pc_mem_q[i]  <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_cnt_q <= drop_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      ins_mem_q  <= ins_mem_d;
      pc_mem_q   <= pc_mem_d;
    end
  end

  assign dec_ins   = ins_mem_q[rd_ptr_q];
  assign dec_pc    = pc_mem_q[rd_ptr_q];
  assign dec_op    = dec_ins[31:26];
  assign dec_rs    = {1'b0, dec_ins[25:21]};
  assign dec_rt    = {1'b0, dec_ins[20:16]};
  assign dec_funct = dec_ins[5:0];

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Directed bench for ins_fetch_queue; a small in-order memory responder supplies words
// derived from the fetch address so every expected value is known by hand.
module tb_ins_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dec_ready;
  logic        dec_valid;
  logic [31:0] dec_ins;
  logic [31:0] dec_pc;
  logic [5:0]  dec_op;
  logic [5:0]  dec_rs;
  logic [5:0]  dec_rt;
  logic [5:0]  dec_funct;

  int          errors = 0;
  int          checks = 0;
  int          grant_cnt = 0;
  logic        rsp_en;
  logic [31:0] pend[$];

  ins_fetch_queue #(.DEPTH(4), .RESET_PC(32'hBFC00000)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .dec_ready(dec_ready), .dec_valid(dec_valid), .dec_ins(dec_ins), .dec_pc(dec_pc),
    .dec_op(dec_op), .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_funct(dec_funct)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a == 32'hBFC00000) ? 32'h00221820 : ~a;
  endfunction

  // One clock: record a grant before the edge, then present the oldest pending response.
  task automatic cycle();
    logic        g;
    logic [31:0] a;
    #1;
    g = imem_req && imem_gnt;
    a = imem_addr;
    @(posedge clk);
    #1;
    if (g) begin
      pend.push_back(a);
      grant_cnt++;
    end
    if (rsp_en && pend.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_gnt = 1'b0;
    dec_ready = 1'b0;
    redirect_valid = 1'b0;
    pend.delete();
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    cycle();
    rst = 1'b0;
    grant_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    dec_ready = 1'b0;
    rsp_en = 1'b1;
    repeat (3) cycle();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rst_dec_valid got=%b exp=0", dec_valid); end
    checks++; if (imem_addr !== 32'hBFC00000) begin errors++; $display("FAIL rst_addr got=%h exp=bfc00000", imem_addr); end
    rst = 1'b0;
    cycle();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL post_rst_req got=%b exp=1", imem_req); end
    checks++; if (dec_ins !== 32'h0) begin errors++; $display("FAIL post_rst_ins got=%h exp=0", dec_ins); end
    checks++; if (dec_pc !== 32'h0) begin errors++; $display("FAIL post_rst_pc got=%h exp=0", dec_pc); end
    checks++; if ({dec_op, dec_rs, dec_rt, dec_funct} !== 24'h0) begin errors++; $display("FAIL post_rst_fields got=%h exp=0", {dec_op, dec_rs, dec_rt, dec_funct}); end
    repeat (2) cycle();
    checks++; if (imem_addr !== 32'hBFC00000) begin errors++; $display("FAIL hold_addr got=%h exp=bfc00000", imem_addr); end
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL hold_dec_valid got=%b exp=0", dec_valid); end
  endtask

  task automatic test_stream();
    imem_gnt = 1'b1;
    dec_ready = 1'b1;
    cycle();
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL stream_lat got=%b exp=0", dec_valid); end
    cycle();
    checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL stream_valid got=%b exp=1", dec_valid); end
    checks++; if (dec_pc !== 32'hBFC00000) begin errors++; $display("FAIL stream_pc0 got=%h exp=bfc00000", dec_pc); end
    checks++; if (dec_ins !== 32'h00221820) begin errors++; $display("FAIL stream_ins0 got=%h exp=00221820", dec_ins); end
    checks++; if ({dec_op, dec_rs, dec_rt, dec_funct} !== {6'd0, 6'd1, 6'd2, 6'h20}) begin
      errors++; $display("FAIL stream_fields got=%h/%h/%h/%h exp=0/1/2/20", dec_op, dec_rs, dec_rt, dec_funct);
    end
    cycle();
    checks++; if (dec_pc !== 32'hBFC00004) begin errors++; $display("FAIL stream_pc1 got=%h exp=bfc00004", dec_pc); end
    cycle();
    checks++; if (dec_pc !== 32'hBFC00008) begin errors++; $display("FAIL stream_pc2 got=%h exp=bfc00008", dec_pc); end
    checks++; if (dec_ins !== 32'h403FFFF7) begin errors++; $display("FAIL stream_ins2 got=%h exp=403ffff7", dec_ins); end
  endtask

  task automatic test_backpressure();
    do_reset();
    imem_gnt = 1'b1;
    dec_ready = 1'b0;
    rsp_en = 1'b1;
    repeat (8) cycle();
    checks++; if (grant_cnt !== 4) begin errors++; $display("FAIL bp_grants got=%0d exp=4", grant_cnt); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req got=%b exp=0", imem_req); end
    checks++; if (dec_pc !== 32'hBFC00000 || dec_valid !== 1'b1) begin errors++; $display("FAIL bp_head got=%h/%b exp=bfc00000/1", dec_pc, dec_valid); end
    dec_ready = 1'b1;
    cycle();
    checks++; if (dec_pc !== 32'hBFC00004) begin errors++; $display("FAIL bp_drain1 got=%h exp=bfc00004", dec_pc); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL bp_resume got=%b exp=1", imem_req); end
    cycle();
    checks++; if (dec_pc !== 32'hBFC00008) begin errors++; $display("FAIL bp_drain2 got=%h exp=bfc00008", dec_pc); end
    cycle();
    checks++; if (dec_pc !== 32'hBFC0000C) begin errors++; $display("FAIL bp_drain3 got=%h exp=bfc0000c", dec_pc); end
    cycle();
    checks++; if (dec_pc !== 32'hBFC00010 || dec_ins !== 32'h403FFFEF) begin errors++; $display("FAIL bp_next got=%h/%h exp=bfc00010/403fffef", dec_pc, dec_ins); end
  endtask

  task automatic test_redirect();
    do_reset();
    imem_gnt = 1'b1;
    dec_ready = 1'b1;
    rsp_en = 1'b0;
    cycle();
    cycle();
    checks++; if (grant_cnt !== 2) begin errors++; $display("FAIL rd_grants got=%0d exp=2", grant_cnt); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h80000102;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rd_req_block got=%b exp=0", imem_req); end
    rsp_en = 1'b1;
    cycle();
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'h80000100) begin errors++; $display("FAIL rd_addr got=%h exp=80000100", imem_addr); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rd_req got=%b exp=1", imem_req); end
    cycle();
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rd_drop1 got=%b exp=0", dec_valid); end
    cycle();
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rd_drop2 got=%b exp=0", dec_valid); end
    cycle();
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h80000100) begin errors++; $display("FAIL rd_first got=%b/%h exp=1/80000100", dec_valid, dec_pc); end
    checks++; if (dec_ins !== 32'h7FFFFEFF) begin errors++; $display("FAIL rd_ins got=%h exp=7ffffeff", dec_ins); end
  endtask

  task automatic test_redirect_pop();
    do_reset();
    imem_gnt = 1'b1;
    dec_ready = 1'b0;
    rsp_en = 1'b1;
    cycle();
    cycle();
    rsp_en = 1'b0;
    cycle();
    rsp_en = 1'b1;
    cycle();
    checks++; if (dec_valid !== 1'b1 || imem_rvalid !== 1'b1) begin errors++; $display("FAIL rp_setup got=%b/%b exp=1/1", dec_valid, imem_rvalid); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h00002000;
    dec_ready = 1'b1;
    cycle();
    redirect_valid = 1'b0;
    #1;
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rp_flush got=%b exp=0", dec_valid); end
    checks++; if (imem_addr !== 32'h00002000) begin errors++; $display("FAIL rp_addr got=%h exp=00002000", imem_addr); end
    cycle();
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rp_drop got=%b exp=0", dec_valid); end
    cycle();
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h00002000) begin errors++; $display("FAIL rp_first got=%b/%h exp=1/00002000", dec_valid, dec_pc); end
    checks++; if (dec_ins !== 32'hFFFFDFFF) begin errors++; $display("FAIL rp_ins got=%h exp=ffffdfff", dec_ins); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc = 32'h00003000;
    cycle();
    redirect_pc = 32'hFFFFFFFC;
    cycle();
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_addr0 got=%h exp=fffffffc", imem_addr); end
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL wrap_flush got=%b exp=0", dec_valid); end
    cycle();
    checks++; if (imem_addr !== 32'h00000000) begin errors++; $display("FAIL wrap_addr1 got=%h exp=00000000", imem_addr); end
    cycle();
    checks++; if (dec_pc !== 32'hFFFFFFFC || dec_ins !== 32'h00000003) begin errors++; $display("FAIL wrap_pc0 got=%h/%h exp=fffffffc/00000003", dec_pc, dec_ins); end
    checks++; if (imem_addr !== 32'h00000004) begin errors++; $display("FAIL wrap_addr2 got=%h exp=00000004", imem_addr); end
    cycle();
    checks++; if (dec_pc !== 32'h00000000 || dec_ins !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_pc1 got=%h/%h exp=00000000/ffffffff", dec_pc, dec_ins); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
